pc_sequencer: RTL and testbench
===============================

# pc_sequencer

Fetch-stage controller that owns the program counter and sequences the existing PC incrementer. Each cycle it picks the next PC from sequential (+4), jump or branch redirect, or hold. It buffers a redirect that arrives during a hazard stall, flags misaligned targets, and drives the IF/ID flush. It sits between the hazard/branch logic in ID/EX and instruction memory.

## Interface
- RESET_PC, 32'h0000_0000, PC value loaded by reset; must be word-aligned
- Clk  in  1  rising-edge clock
- Reset  in  1  asynchronous, active-high; forces the reset state immediately
- Stall  in  1  hazard unit hold request; PC must not advance
- Halt  in  1  stop fetching; terminal until Reset
- Jump  in  1  jump redirect request
- JumpTarget  in  32  jump destination
- BranchTaken  in  1  resolved taken-branch redirect request
- BranchTarget  in  32  branch destination
- PCResult  out  32  current fetch address (registered)
- PCAddResult  out  32  PCResult + 4 (combinational)
- FetchValid  out  1  instruction memory output at PCResult is to be consumed
- Flush  out  1  squash IF/ID; registered, one-cycle pulse
- Misaligned  out  1  sticky; a redirect target had bits [1:0] != 0

## Operation
- States: BOOT, RUN, HOLD, HALT.
- Reset (async) forces: state BOOT, PCResult = RESET_PC, Flush = 0, Misaligned = 0, Pending = 0, PendTarget = 0.
- BOOT: PC held. The next edge always goes to RUN, ignoring all inputs.
- FetchValid = 1 in RUN and HOLD, 0 in BOOT and HALT. It is decoded from the state register only.
- Redirect request = Jump | BranchTaken. If both are set, Jump wins and its target is JumpTarget.
- Per-edge priority in RUN/HOLD:
  1. Halt: go to HALT; PC held; Pending cleared.
  2. Stall = 1: go to HOLD; PC held. If a redirect is present and Pending = 0, set Pending = 1 and PendTarget = target. If Pending = 1 already, the new redirect is dropped (the older one wins).
  3. Stall = 0, Pending = 1: apply PendTarget, clear Pending, go to RUN. Any simultaneous redirect is dropped.
  4. Stall = 0, redirect present: apply its target, go to RUN.
  5. Otherwise: PC = PCAddResult, go to RUN.
- Apply target: if target[1:0] == 0, PC = target and Flush = 1 on the next cycle. If misaligned, PC is held, Misaligned = 1, go to HALT, Flush stays 0.
- Flush = 0 on every edge that does not apply an aligned target.
- HALT: all inputs except Reset are ignored; PC frozen; Misaligned holds its value.
- Arithmetic: 32-bit unsigned, modulo 2^32. 32'hFFFF_FFFC + 4 = 32'h0000_0000, with no flag.

## Timing
- Sequential path: PCResult advances by 4 every edge in RUN when no event is present. PCAddResult follows PCResult combinationally in the same cycle.
- Redirect latency: a request sampled at edge n gives PCResult = target after edge n. Flush is high from edge n to edge n+1.
- Stalled redirect: the target is captured at the first stalled edge. It is applied at the first edge with Stall = 0, so PCResult changes one edge after Stall falls.
- Halt takes effect at the sampling edge. FetchValid is low from the following cycle.
- Reset deasserted before edge k: edge k moves BOOT to RUN with PC still RESET_PC. The first PC increment happens at edge k+1.
- Reset mid-operation: all state and the pending buffer are lost immediately, with no glitch dependence on Clk.

## Structure
- Package pc_seq_pkg holds:
  - the state encoding (2-bit enum: BOOT, RUN, HOLD, HALT);
  - PC_INC = 32'd4;
  - the alignment-check function.
- One sub-module: instantiate the existing PCAdder for the increment, with PCResult in and PCAddResult out.
- Everything else stays in one file: the state register, the PC register, the Pending/PendTarget buffer and the Flush register.

## Test plan
- Reset with RESET_PC = 32'h100, release, run 4 edges -> PCResult sequence 100, 100, 104, 108, 10C; FetchValid rises after the first edge.
- At PC 32'h200, Jump = 1 and BranchTaken = 1 in the same cycle, JumpTarget = 32'h400, BranchTarget = 32'h300 -> PCResult = 32'h400, Flush high for exactly one cycle.
- Stall held for 3 cycles with BranchTaken/32'h500 on stall cycle 1 and Jump/32'h600 on stall cycle 2 -> PC frozen during the stall, then 32'h500 one edge after Stall falls; 32'h600 never appears.
- BranchTarget = 32'h302 -> PC held, Misaligned = 1, FetchValid = 0, Flush stays 0; later inputs have no effect until Reset, which clears Misaligned.
- PC reaches 32'hFFFF_FFFC via a jump, no stall -> next PCResult = 32'h0000_0000 with no error.
- Halt asserted at PC 32'h20 -> PC frozen at 32'h20, FetchValid = 0. Asserting Reset mid-cycle returns PCResult to RESET_PC immediately, without waiting for a clock edge.

Source files
------------

// File: rtl/pc_seq_pkg.sv
// Shared types and helpers for the fetch-stage PC sequencer.
package pc_seq_pkg;

    typedef enum logic [1:0] {
        ST_BOOT = 2'd0,
        ST_RUN  = 2'd1,
        ST_HOLD = 2'd2,
        ST_HALT = 2'd3
    } pc_state_e;

    localparam logic [31:0] PC_INC = 32'd4;

    function automatic logic is_aligned(input logic [31:0] addr);
        return addr[1:0] == 2'b00;
    endfunction

endpackage

// File: rtl/pc_adder.sv
// Existing PC incrementer: next sequential fetch address.
module PCAdder
    import pc_seq_pkg::*;
(
    input  logic [31:0] PCResult,
    output logic [31:0] PCAddResult
);

    assign PCAddResult = PCResult + PC_INC;

endmodule

// File: rtl/pc_sequencer.sv
// Fetch-stage controller: owns the PC, picks sequential/redirect/hold,
// buffers redirects seen during a stall and drives the IF/ID flush.
module pc_sequencer
    import pc_seq_pkg::*;
#(
    parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic        Stall,
    input  logic        Halt,
    input  logic        Jump,
    input  logic [31:0] JumpTarget,
    input  logic        BranchTaken,
    input  logic [31:0] BranchTarget,
    output logic [31:0] PCResult,
    output logic [31:0] PCAddResult,
    output logic        FetchValid,
    output logic        Flush,
    output logic        Misaligned
);

    pc_state_e   state_q, state_d;
    logic [31:0] pc_q, pc_d;
    logic        pend_q, pend_d;
    logic [31:0] pend_tgt_q, pend_tgt_d;
    logic        flush_q, flush_d;
    logic        mis_q, mis_d;

    logic        redir;
    logic [31:0] redir_tgt;
    logic [31:0] pc_add;
    logic        do_apply;
    logic [31:0] apply_tgt;

    PCAdder u_pc_adder (
        .PCResult    (pc_q),
        .PCAddResult (pc_add)
    );

    assign redir     = Jump | BranchTaken;
    assign redir_tgt = Jump ? JumpTarget : BranchTarget;

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        pend_d     = pend_q;
        pend_tgt_d = pend_tgt_q;
        flush_d    = 1'b0;
        mis_d      = mis_q;
        do_apply   = 1'b0;
        apply_tgt  = 32'h0;

        unique case (state_q)
            ST_BOOT: state_d = ST_RUN;
            ST_RUN, ST_HOLD: begin
                if (Halt) begin
                    state_d = ST_HALT;
                    pend_d  = 1'b0;
                end else if (Stall) begin
                    state_d = ST_HOLD;
                    // Oldest redirect wins; later ones are dropped.
                    if (redir && !pend_q) begin
                        pend_d     = 1'b1;
                        pend_tgt_d = redir_tgt;
                    end
                end else if (pend_q) begin
                    pend_d    = 1'b0;
                    do_apply  = 1'b1;
                    apply_tgt = pend_tgt_q;
                end else if (redir) begin
                    do_apply  = 1'b1;
                    apply_tgt = redir_tgt;
                end else begin
                    state_d = ST_RUN;
                    pc_d    = pc_add;
                end

                if (do_apply) begin
                    if (is_aligned(apply_tgt)) begin
                        state_d = ST_RUN;
                        pc_d    = apply_tgt;
                        flush_d = 1'b1;
                    end else begin
                        state_d = ST_HALT;
                        mis_d   = 1'b1;
                    end
                end
            end
            ST_HALT: state_d = ST_HALT;
            default: state_d = ST_BOOT;
        endcase
    end

    always_ff @(posedge Clk or posedge Reset) begin
        if (Reset) begin
            state_q    <= ST_BOOT;
            pc_q       <= RESET_PC;
            pend_q     <= 1'b0;
            pend_tgt_q <= 32'h0;
            flush_q    <= 1'b0;
            mis_q      <= 1'b0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
            flush_q    <= flush_d;
            mis_q      <= mis_d;
        end
    end

    assign PCResult    = pc_q;
    assign PCAddResult = pc_add;
    assign FetchValid  = (state_q == ST_RUN) || (state_q == ST_HOLD);
    assign Flush       = flush_q;
    assign Misaligned  = mis_q;

endmodule

// File: tb/tb_pc_sequencer.sv
// Directed bench for pc_sequencer with hand-computed expectations.
module tb_pc_sequencer;

    logic        Clk = 1'b0;
    logic        Reset;
    logic        Stall;
    logic        Halt;
    logic        Jump;
    logic [31:0] JumpTarget;
    logic        BranchTaken;
    logic [31:0] BranchTarget;
    logic [31:0] PCResult;
    logic [31:0] PCAddResult;
    logic        FetchValid;
    logic        Flush;
    logic        Misaligned;

    int n_vec = 0;
    int n_err = 0;

    pc_sequencer #(.RESET_PC(32'h100)) dut (
        .Clk          (Clk),
        .Reset        (Reset),
        .Stall        (Stall),
        .Halt         (Halt),
        .Jump         (Jump),
        .JumpTarget   (JumpTarget),
        .BranchTaken  (BranchTaken),
        .BranchTarget (BranchTarget),
        .PCResult     (PCResult),
        .PCAddResult  (PCAddResult),
        .FetchValid   (FetchValid),
        .Flush        (Flush),
        .Misaligned   (Misaligned)
    );

    always #5 Clk = ~Clk;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic idle();
        Stall = 0; Halt = 0; Jump = 0; BranchTaken = 0;
        JumpTarget = 32'h0; BranchTarget = 32'h0;
    endtask

    // Advance one edge; sample 1 time unit after it.
    task automatic step();
        @(posedge Clk);
        #1;
    endtask

    initial begin
        idle();
        Reset = 1;
        #2;
        chk("rst_pc", PCResult, 32'h100);
        chk("rst_fv", {31'b0, FetchValid}, 32'd0);
        chk("rst_flush", {31'b0, Flush}, 32'd0);
        chk("rst_mis", {31'b0, Misaligned}, 32'd0);
        chk("rst_add", PCAddResult, 32'h104);
        step();
        Reset = 0;

        step();
        chk("boot_pc", PCResult, 32'h100);
        chk("boot_fv", {31'b0, FetchValid}, 32'd1);
        step();
        chk("seq1", PCResult, 32'h104);
        step();
        chk("seq2", PCResult, 32'h108);
        step();
        chk("seq3", PCResult, 32'h10C);

        Jump = 1; JumpTarget = 32'h200;
        step();
        chk("j200", PCResult, 32'h200);
        chk("j200_fl", {31'b0, Flush}, 32'd1);

        Jump = 1; JumpTarget = 32'h400;
        BranchTaken = 1; BranchTarget = 32'h300;
        step();
        chk("both", PCResult, 32'h400);
        chk("both_fl", {31'b0, Flush}, 32'd1);
        idle();
        step();
        chk("post_j", PCResult, 32'h404);
        chk("post_j_fl", {31'b0, Flush}, 32'd0);

        Stall = 1; BranchTaken = 1; BranchTarget = 32'h500;
        step();
        chk("st1", PCResult, 32'h404);
        chk("st1_fv", {31'b0, FetchValid}, 32'd1);
        chk("st1_fl", {31'b0, Flush}, 32'd0);
        BranchTaken = 0; Jump = 1; JumpTarget = 32'h600;
        step();
        chk("st2", PCResult, 32'h404);
        Jump = 0;
        step();
        chk("st3", PCResult, 32'h404);
        Stall = 0;
        step();
        chk("st_apply", PCResult, 32'h500);
        chk("st_apply_fl", {31'b0, Flush}, 32'd1);
        step();
        chk("st_after", PCResult, 32'h504);
        chk("st_after_fl", {31'b0, Flush}, 32'd0);

        Jump = 1; JumpTarget = 32'hFFFF_FFFC;
        step();
        chk("top", PCResult, 32'hFFFF_FFFC);
        chk("top_add", PCAddResult, 32'h0);
        idle();
        step();
        chk("wrap", PCResult, 32'h0);
        chk("wrap_mis", {31'b0, Misaligned}, 32'd0);
        chk("wrap_fv", {31'b0, FetchValid}, 32'd1);

        Jump = 1; JumpTarget = 32'h20;
        step();
        chk("j20", PCResult, 32'h20);
        idle();
        Halt = 1;
        step();
        chk("halt_pc", PCResult, 32'h20);
        chk("halt_fv", {31'b0, FetchValid}, 32'd0);
        idle();
        Jump = 1; JumpTarget = 32'h40;
        step();
        chk("halt_frz", PCResult, 32'h20);
        idle();

        #2;
        Reset = 1;
        #1;
        chk("mid_rst_pc", PCResult, 32'h100);
        chk("mid_rst_fv", {31'b0, FetchValid}, 32'd0);
        step();
        Reset = 0;
        step();
        chk("boot2_pc", PCResult, 32'h100);
        step();
        chk("boot2_seq", PCResult, 32'h104);

        BranchTaken = 1; BranchTarget = 32'h302;
        step();
        chk("mis_pc", PCResult, 32'h104);
        chk("mis_flag", {31'b0, Misaligned}, 32'd1);
        chk("mis_fv", {31'b0, FetchValid}, 32'd0);
        chk("mis_fl", {31'b0, Flush}, 32'd0);
        idle();
        Jump = 1; JumpTarget = 32'h400;
        step();
        chk("mis_frz", PCResult, 32'h104);
        chk("mis_stick", {31'b0, Misaligned}, 32'd1);
        idle();
        Reset = 1;
        #1;
        chk("mis_clr", {31'b0, Misaligned}, 32'd0);
        chk("mis_rst_pc", PCResult, 32'h100);
        Reset = 0;
        step();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
